// File: rtl/inval_line_coalescer.sv
// Line-aligns L1 invalidation requests, drops lines already pending or recently issued, and queues
// the rest. Optional counters behind `INVAL_COALESCE_STATS_EN.
module inval_line_coalescer #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned HistDepth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] inval_addr_i,
  input  logic                 inval_valid_i,
  output logic                 inval_ready_o,
  input  logic                 hist_clear_i,
  output logic [AddrWidth-1:0] l1_inval_addr_o,
  output logic                 l1_inval_valid_o,
  input  logic                 l1_inval_ready_i
`ifdef INVAL_COALESCE_STATS_EN
  ,
  output logic [31:0]          stat_rx_o,
  output logic [31:0]          stat_drop_o,
  output logic [31:0]          stat_issue_o
`endif
);

  localparam int unsigned OffW  = $clog2(L1LineWidth);
  localparam int unsigned TagW  = AddrWidth - OffW;
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HPtrW = (HistDepth > 1) ? $clog2(HistDepth) : 1;

  typedef logic [TagW-1:0] tag_t;

  tag_t                 in_tag;
  tag_t                 fifo_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FifoDepth-1:0] fifo_vld;

  tag_t                 hist_q [HistDepth];
  logic [HistDepth-1:0] hist_vld_q;
  logic [HPtrW-1:0]     hist_ptr_q;

  logic empty, full, pend_hit, hist_hit, drop, push, pop;

  assign in_tag = inval_addr_i[AddrWidth-1:OffW];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CntW'(FifoDepth));

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    fifo_vld = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      fifo_vld[i] = ({1'b0, PtrW'(PtrW'(i) - rd_ptr_q)} < cnt_q);
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (fifo_vld[i] && (fifo_q[i] == in_tag)) pend_hit = 1'b1;
    end
  end

  always_comb begin
    hist_hit = 1'b0;
    for (int i = 0; i < HistDepth; i++) begin
      if (hist_vld_q[i] && (hist_q[i] == in_tag)) hist_hit = 1'b1;
    end
    if (hist_clear_i) hist_hit = 1'b0;
  end

  assign drop          = inval_valid_i && (pend_hit || hist_hit);
  assign push          = inval_valid_i && !drop && !full;
  assign pop           = !empty && l1_inval_ready_i;
  assign inval_ready_o = drop || !full;

  assign l1_inval_valid_o = !empty;
  assign l1_inval_addr_o  = empty ? '0 : {fifo_q[rd_ptr_q], {OffW{1'b0}}};

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= in_tag;
    end
  end

  // A clear and a pop in the same cycle leave only the popped line valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HistDepth; i++) hist_q[i] <= '0;
      hist_vld_q <= '0;
      hist_ptr_q <= '0;
    end else begin
      if (hist_clear_i) hist_vld_q <= '0;
      if (pop) begin
        hist_q[hist_ptr_q]     <= fifo_q[rd_ptr_q];
        hist_vld_q[hist_ptr_q] <= 1'b1;
        hist_ptr_q             <= (hist_ptr_q == HPtrW'(HistDepth - 1)) ? '0
                                                                        : hist_ptr_q + HPtrW'(1);
      end
    end
  end

`ifdef INVAL_COALESCE_STATS_EN
  logic [31:0] stat_rx_q, stat_drop_q, stat_issue_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_rx_q    <= '0;
      stat_drop_q  <= '0;
      stat_issue_q <= '0;
    end else begin
      if (inval_valid_i && inval_ready_o) stat_rx_q <= stat_rx_q + 32'd1;
      if (drop) stat_drop_q  <= stat_drop_q + 32'd1;
      if (pop)  stat_issue_q <= stat_issue_q + 32'd1;
    end
  end

  assign stat_rx_o    = stat_rx_q;
  assign stat_drop_o  = stat_drop_q;
  assign stat_issue_o = stat_issue_q;
`endif

endmodule

// File: tb/tb_inval_line_coalescer.sv
// Directed bench for inval_line_coalescer: expected L1 lines are queued at acceptance and a
// negedge monitor checks every L1 handshake against the queue.
module tb_inval_line_coalescer;

  logic        clk;
  logic        rst_n;
  logic [63:0] inval_addr;
  logic        inval_valid;
  logic        inval_ready;
  logic        hist_clear;
  logic [63:0] l1_addr;
  logic        l1_valid;
  logic        l1_ready;

  int vecs = 0;
  int errs = 0;
  logic [63:0] exp_q[$];

  inval_line_coalescer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .inval_addr_i     (inval_addr),
    .inval_valid_i    (inval_valid),
    .inval_ready_o    (inval_ready),
    .hist_clear_i     (hist_clear),
    .l1_inval_addr_o  (l1_addr),
    .l1_inval_valid_o (l1_valid),
    .l1_inval_ready_i (l1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every L1 handshake must match the oldest expected line.
  always @(negedge clk) begin
    if (rst_n && l1_valid && l1_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_issue: got %h expected none", l1_addr);
      end else begin
        chk("issue_addr", l1_addr, exp_q.pop_front());
      end
    end
  end

  // Tasks start and end just after a rising edge.
  task automatic send(input logic [63:0] a, input bit issue);
    inval_valid = 1'b1;
    inval_addr  = a;
    @(negedge clk);
    chk("in_ready", {63'd0, inval_ready}, 64'd1);
    if (issue) exp_q.push_back(a & ~64'hF);
    @(posedge clk);
    #1;
    inval_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    inval_valid = 1'b0;
    inval_addr  = '0;
    hist_clear  = 1'b0;
    l1_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, l1_valid}, 64'd0);
    chk("rst_addr", l1_addr, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: single request, one-cycle latency
    send(64'h1004, 1'b1);
    @(negedge clk);
    chk("t1_lat_valid", {63'd0, l1_valid}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_empty", {63'd0, l1_valid}, 64'd0);
    @(posedge clk);
    #1;

    // 2: same line three times while L1 stalls -> one entry
    l1_ready = 1'b0;
    send(64'h2000, 1'b1);
    send(64'h2008, 1'b0);
    send(64'h200C, 1'b0);
    @(negedge clk);
    chk("t2_head", l1_addr, 64'h2000);
    @(posedge clk);
    #1;
    l1_ready = 1'b1;
    idle(3);
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // 3: history drop, then clear re-enables the line
    send(64'h3000, 1'b1);
    idle(1);
    send(64'h3004, 1'b0);
    hist_clear = 1'b1;
    idle(1);
    hist_clear = 1'b0;
    send(64'h3008, 1'b1);
    idle(2);

    // 4: fill the FIFO, fifth waits for a pop and is accepted only after it
    l1_ready = 1'b0;
    send(64'h4000, 1'b1);
    send(64'h4010, 1'b1);
    send(64'h4020, 1'b1);
    send(64'h4030, 1'b1);
    inval_valid = 1'b1;
    inval_addr  = 64'h4040;
    @(negedge clk);
    chk("t4_full_ready", {63'd0, inval_ready}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_full_ready2", {63'd0, inval_ready}, 64'd0);
    @(posedge clk);
    #1;
    l1_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_same_cycle", {63'd0, inval_ready}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_after_pop", {63'd0, inval_ready}, 64'd1);
    exp_q.push_back(64'h4040);
    @(posedge clk);
    #1;
    inval_valid = 1'b0;
    idle(6);
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // 5: six lines overflow the 4-deep history; the oldest is issued again
    for (int i = 0; i < 6; i++) send(64'h5000 + 64'(i * 16), 1'b1);
    idle(2);
    send(64'h5000, 1'b1);
    send(64'h5050, 1'b0);
    idle(2);

    // Clear coinciding with a pop keeps the popped line in history
    send(64'h6000, 1'b1);
    hist_clear = 1'b1;
    idle(1);
    hist_clear = 1'b0;
    send(64'h6004, 1'b0);
    send(64'h5040, 1'b1);
    idle(2);
    chk("t5_drain", 64'(exp_q.size()), 64'd0);

    // 6: async reset with pending entries discards them
    l1_ready = 1'b0;
    send(64'h7000, 1'b1);
    send(64'h7010, 1'b1);
    send(64'h7020, 1'b1);
    @(negedge clk);
    chk("t6_pending", {63'd0, l1_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, l1_valid}, 64'd0);
    chk("t6_rst_addr", l1_addr, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    l1_ready = 1'b1;
    idle(5);
    @(negedge clk);
    chk("t6_no_issue", {63'd0, l1_valid}, 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
